// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer that drives an external adder and runs one outstanding instruction fetch.
// Optional misaligned-redirect trap is enabled by defining PC_MISALIGN_TRAP_EN.
//
// state | meaning
// REQ   | fetch request outstanding (suppressed by stall or redirect)
// HOLD  | fetched instruction presented to decode, waiting for instr_ready
// HALT  | misaligned redirect trapped, waits for reset (PC_MISALIGN_TRAP_EN only)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INCR     = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] res,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        trap
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    assign op1       = pc;
    assign op2       = INCR;
    assign imem_addr = pc;
    // rst_n gating keeps the request low while reset is held, since state already reads REQ
    assign imem_req  = rst_n & (state == ST_REQ) & ~stall & ~redirect;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_REQ, ST_HOLD: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (redirect_pc[1:0] != 2'b00) begin
                            state  <= ST_HALT;
                            trap_q <= 1'b1;
                        end else begin
                            pc    <= redirect_pc;
                            state <= ST_REQ;
                        end
`else
                        pc    <= redirect_pc & 32'hFFFF_FFFC;
                        state <= ST_REQ;
`endif
                    end else if (state == ST_REQ) begin
                        if (imem_req && imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= res;
                            instr_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: scoreboard of expected fetch addresses checked on each decode handshake.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, instr_ready, ack_en;
    logic [31:0] redirect_pc;
    logic [31:0] op1, op2, res, imem_addr, imem_rdata, instr, instr_pc;
    logic        imem_req, imem_ack, instr_valid, trap;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    // adder and memory models
    assign res        = op1 + op2;
    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = imem_addr ^ 32'h1357_9BDF;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .op1(op1), .op2(op2), .res(res),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .trap(trap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // monitor: every accepted instruction must match the next expected fetch
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_instr_pc", instr_pc, e);
                chk("sb_instr", instr, e ^ 32'h1357_9BDF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        ack_en = 1'b1; instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_trap", {31'h0, trap}, 32'h0);
        chk("rst_op2", op2, 32'd4);

        // sequential fetch, one instruction every two cycles
        rst_n = 1'b1;
        sb.push_back(32'd0); sb.push_back(32'd4); sb.push_back(32'd8); sb.push_back(32'd12);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("seq_req", {31'h0, imem_req}, 32'h1);
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_op1", op1, 32'(4 * k));
            cyc(); #1;
            chk("seq_valid", {31'h0, instr_valid}, 32'h1);
            chk("seq_instr_pc", instr_pc, 32'(4 * k));
            chk("seq_hold_req", {31'h0, imem_req}, 32'h0);
            cyc();
        end

        // decode back-pressure for three cycles
        instr_ready = 1'b0;
        sb.push_back(32'd16);
        #1 chk("bp_req", imem_addr, 32'd16);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_instr_pc", instr_pc, 32'd16);
            chk("bp_instr", instr, 32'd16 ^ 32'h1357_9BDF);
            chk("bp_req_low", {31'h0, imem_req}, 32'h0);
            chk("bp_pc", imem_addr, 32'd20);
            cyc();
        end
        instr_ready = 1'b1;
        cyc();
        sb.push_back(32'd20);
        #1;
        chk("bp_resume_req", {31'h0, imem_req}, 32'h1);
        chk("bp_resume_addr", imem_addr, 32'd20);
        cyc(); cyc();

        // stall two cycles in REQ
        stall = 1'b1;
        #1 chk("stall_req", {31'h0, imem_req}, 32'h0);
        chk("stall_addr", imem_addr, 32'd24);
        cyc(); #1;
        chk("stall_req2", {31'h0, imem_req}, 32'h0);
        chk("stall_addr2", imem_addr, 32'd24);
        cyc();
        stall = 1'b0;
        sb.push_back(32'd24);
        #1 chk("stall_resume", {31'h0, imem_req}, 32'h1);
        cyc(); cyc();

        // redirect drops a held instruction even with ready high
        instr_ready = 1'b0;
        #1;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0100; instr_ready = 1'b1;
        #1;
        chk("redir_held_pc", instr_pc, 32'd28);
        chk("redir_req", {31'h0, imem_req}, 32'h0);
        cyc();
        redirect = 1'b0;
        sb.push_back(32'h100);
        #1;
        chk("redir_valid", {31'h0, instr_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req_on", {31'h0, imem_req}, 32'h1);
        cyc(); #1;
        chk("redir_instr_pc", instr_pc, 32'h100);
        cyc();

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1 chk("wrap_redir_req", {31'h0, imem_req}, 32'h0);
        cyc();
        redirect = 1'b0;
        sb.push_back(32'hFFFF_FFFC);
        #1 chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("wrap_next", imem_addr, 32'h0);
        cyc();
        sb.push_back(32'h0);
        cyc(); cyc();

        // misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        #1;
        cyc();
        redirect = 1'b0;
        #1;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_trap", {31'h0, trap}, 32'h1);
        chk("mis_req", {31'h0, imem_req}, 32'h0);
        chk("mis_valid", {31'h0, instr_valid}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("halt_req", {31'h0, imem_req}, 32'h0);
            chk("halt_trap", {31'h0, trap}, 32'h1);
        end
        redirect = 1'b0;
        rst_n = 1'b0;
        #1 chk("halt_rst_trap", {31'h0, trap}, 32'h0);
        cyc();
        rst_n = 1'b1;
        sb.push_back(32'h0);
        #1 chk("halt_rst_addr", imem_addr, 32'h0);
        cyc(); cyc();
`else
        chk("mis_trap", {31'h0, trap}, 32'h0);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_req", {31'h0, imem_req}, 32'h1);
        sb.push_back(32'h100);
        cyc(); cyc();
`endif

        // reset while an instruction is held
        instr_ready = 1'b0;
        #1;
        cyc(); #1;
        chk("mid_valid", {31'h0, instr_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_pc", instr_pc, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        cyc();
        ack_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("noack_req", {31'h0, imem_req}, 32'h1);
        chk("noack_addr", imem_addr, 32'h0);
        cyc(); #1;
        chk("noack_hold_addr", imem_addr, 32'h0);
        chk("noack_valid", {31'h0, instr_valid}, 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
